// File: rtl/weight_fetch_ctrl.sv
// Weight BRAM sequencer: streams host words into the BRAM (load pass) and reads
// them back in order into a 2-entry buffer feeding the MAC (fetch pass).
module weight_fetch_ctrl #(
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              LOAD_START,
    input  logic [DATA_W-1:0] HOST_DI,
    input  logic              HOST_VALID,
    output logic              HOST_READY,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic              BRAM_EN,
    output logic              BRAM_WE,
    output logic [DATA_W-1:0] BRAM_DI,
    input  logic [DATA_W-1:0] BRAM_DO,
    output logic [DATA_W-1:0] W_DATA,
    output logic [ADDR_W-1:0] W_IDX,
    output logic              W_VALID,
    output logic              W_LAST,
    input  logic              W_READY,
    output logic              BUSY,
    output logic              DONE
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FETCH = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   CNT_END  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   rd_cnt;
    logic [DATA_W-1:0] fifo_data [2];
    logic [ADDR_W-1:0] fifo_idx  [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        fifo_count;
    logic              done_q;
    logic              pop;
    logic              issue;
    logic              load_wr;
    logic              load_last;
    logic              fetch_last;

    assign W_VALID    = (fifo_count != 2'd0);
    assign W_DATA     = fifo_data[rd_ptr];
    assign W_IDX      = fifo_idx[rd_ptr];
    assign W_LAST     = W_VALID && (W_IDX == IDX_LAST);
    assign DONE       = done_q;
    assign pop        = W_VALID && W_READY;
    assign load_wr    = (state == S_LOAD) && HOST_VALID;
    assign load_last  = load_wr && (wr_cnt == CNT_LAST);
    assign fetch_last = pop && W_LAST;

    // A read lands in the buffer at the posedge closing its issue cycle, so the
    // buffer occupancy already accounts for every earlier issue.
    assign issue = (state == S_FETCH) && (rd_cnt < CNT_END) &&
                   ((fifo_count < 2'd2) || pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (LOAD_START)  state_next = S_LOAD;
                else if (START)  state_next = S_FETCH;
            end
            S_LOAD:  if (load_last)  state_next = S_IDLE;
            S_FETCH: if (fetch_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        HOST_READY = 1'b0;
        BUSY       = (state != S_IDLE);
        BRAM_EN    = 1'b0;
        BRAM_WE    = 1'b0;
        BRAM_ADDR  = '0;
        BRAM_DI    = '0;
        case (state)
            S_LOAD: begin
                HOST_READY = 1'b1;
                if (HOST_VALID) begin
                    BRAM_EN   = 1'b1;
                    BRAM_WE   = 1'b1;
                    BRAM_ADDR = wr_cnt[ADDR_W-1:0];
                    BRAM_DI   = HOST_DI;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    BRAM_EN   = 1'b1;
                    BRAM_ADDR = rd_cnt[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Counters idle at zero so every pass starts from address 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (state == S_IDLE) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (load_wr && (wr_cnt < CNT_END)) wr_cnt <= wr_cnt + 1'b1;
            if (issue)                         rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
            end
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (issue) begin
                fifo_data[wr_ptr] <= BRAM_DO;
                fifo_idx[wr_ptr]  <= rd_cnt[ADDR_W-1:0];
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, issue} - {1'b0, pop};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) done_q <= 1'b0;
        else        done_q <= load_last || fetch_last;
    end
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed/random bench for weight_fetch_ctrl with a BRAM model and a
// word-level reference of what every pass must write and deliver.
module tb_weight_fetch_ctrl;
    localparam int DEPTH  = 28;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              START = 1'b0;
    logic              LOAD_START = 1'b0;
    logic [DATA_W-1:0] HOST_DI = '0;
    logic              HOST_VALID = 1'b0;
    logic              HOST_READY;
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic              BRAM_EN;
    logic              BRAM_WE;
    logic [DATA_W-1:0] BRAM_DI;
    logic [DATA_W-1:0] BRAM_DO;
    logic [DATA_W-1:0] W_DATA;
    logic [ADDR_W-1:0] W_IDX;
    logic              W_VALID;
    logic              W_LAST;
    logic              W_READY = 1'b0;
    logic              BUSY;
    logic              DONE;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0]        bram    [2**ADDR_W];
    logic [DATA_W-1:0]        ref_mem [DEPTH];
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    weight_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .LOAD_START(LOAD_START),
        .HOST_DI(HOST_DI), .HOST_VALID(HOST_VALID), .HOST_READY(HOST_READY),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
        .BRAM_DI(BRAM_DI), .BRAM_DO(BRAM_DO), .W_DATA(W_DATA), .W_IDX(W_IDX),
        .W_VALID(W_VALID), .W_LAST(W_LAST), .W_READY(W_READY), .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Single-port BRAM: access on negedge, DO held when not reading.
    always @(negedge CLK) begin
        if (BRAM_EN) begin
            if (BRAM_WE) bram[BRAM_ADDR] <= BRAM_DI;
            else         BRAM_DO <= bram[BRAM_ADDR];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check({tag, "_busy"}, BUSY, 0);
            check({tag, "_en"}, BRAM_EN, 0);
            check({tag, "_wvalid"}, W_VALID, 0);
            check({tag, "_done"}, DONE, 0);
            @(posedge CLK); #1;
        end
    endtask

    task automatic run_load(input bit rnd, input bit with_start, input string tag);
        int cyc = 0;
        int wcnt = 0;
        int last_cyc = -1;
        int dones = 0;
        int stall = 0;
        bit in_load;
        logic [DATA_W-1:0] words [DEPTH];
        for (int i = 0; i < DEPTH; i++)
            words[i] = rnd ? DATA_W'($urandom) : DATA_W'(16'h0100 + i);
        LOAD_START = 1'b1;
        START      = with_start;
        HOST_VALID = 1'b0;
        while (cyc < 300) begin
            if (cyc >= 1) begin
                LOAD_START = 1'b0;
                START      = 1'b0;
                if (wcnt >= DEPTH) HOST_VALID = 1'b0;
                else if (stall > 0) begin
                    HOST_VALID = 1'b0;
                    stall--;
                end else HOST_VALID = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                HOST_DI = (HOST_VALID && wcnt < DEPTH) ? words[wcnt] : DATA_W'($urandom);
            end
            @(negedge CLK);
            in_load = (cyc >= 1) && (last_cyc < 0);
            check({tag, "_ready"}, HOST_READY, in_load);
            check({tag, "_busy"}, BUSY, in_load);
            check({tag, "_done"}, DONE, (last_cyc >= 0) && (cyc == last_cyc + 1));
            if (DONE) dones++;
            if (in_load && HOST_VALID) begin
                check({tag, "_en"}, BRAM_EN, 1);
                check({tag, "_we"}, BRAM_WE, 1);
                check({tag, "_addr"}, BRAM_ADDR, wcnt);
                check({tag, "_di"}, BRAM_DI, words[wcnt]);
                ref_mem[wcnt] = words[wcnt];
                if (wcnt == DEPTH - 1) last_cyc = cyc;
                if (!rnd && wcnt == 10) stall = 3;
                wcnt++;
            end else begin
                check({tag, "_nowe"}, BRAM_WE, 0);
                check({tag, "_noen"}, BRAM_EN, 0);
            end
            @(posedge CLK); #1;
            cyc++;
            if (last_cyc >= 0 && cyc > last_cyc + 3) break;
        end
        HOST_VALID = 1'b0;
        check({tag, "_words"}, wcnt, DEPTH);
        check({tag, "_dones"}, dones, 1);
    endtask

    // mode 0: ready always, 1: ready 1,0,0,1 pattern, 2: random, 3: ready low cycles 0..10
    task automatic run_fetch(input int mode, input bit poke, input string tag);
        int cyc = 0;
        int issued = 0;
        int popped = 0;
        int dones = 0;
        int fin_cyc = -1;
        int buffered;
        bit poked = 0;
        bit poke_now = 0;
        bit stall = 0;
        bit rdy;
        bit pop;
        logic [DATA_W-1:0] pdata = '0;
        logic [ADDR_W-1:0] pidx = '0;
        logic [ADDR_W+DATA_W-1:0] e;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), ref_mem[i]});
        while (cyc < 600) begin
            START = (cyc == 0) || poke_now;
            poke_now = 0;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       rdy = ($urandom_range(0, 2) != 0);
                default: rdy = (cyc > 10);
            endcase
            W_READY = rdy;
            @(negedge CLK);
            buffered = issued - popped;
            pop = (buffered > 0) && rdy;
            check({tag, "_busy"}, BUSY, (cyc >= 1) && (fin_cyc < 0));
            check({tag, "_done"}, DONE, (fin_cyc >= 0) && (cyc == fin_cyc + 1));
            if (DONE) dones++;
            check({tag, "_wvalid"}, W_VALID, buffered > 0);
            if (mode == 0) check({tag, "_wvalid_t"}, W_VALID, (cyc >= 2) && (cyc <= DEPTH + 1));
            if (mode == 3 && cyc >= 1 && cyc <= 10) check({tag, "_hold_en"}, BRAM_EN, cyc <= 2);
            if (mode == 3 && cyc >= 11 && popped < DEPTH) check({tag, "_b2b"}, W_VALID, 1);
            if (stall) begin
                check({tag, "_stable_v"}, W_VALID, 1);
                check({tag, "_stable_d"}, W_DATA, pdata);
                check({tag, "_stable_i"}, W_IDX, pidx);
            end
            if (BRAM_EN) begin
                check({tag, "_rd_we"}, BRAM_WE, 0);
                check({tag, "_rd_addr"}, BRAM_ADDR, issued);
                check({tag, "_credit"}, (buffered < 2) || pop, 1);
                check({tag, "_overissue"}, issued < DEPTH, 1);
                issued++;
            end
            if (pop) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_idx"}, W_IDX, e[DATA_W +: ADDR_W]);
                    check({tag, "_data"}, W_DATA, e[DATA_W-1:0]);
                    check({tag, "_last"}, W_LAST, e[DATA_W +: ADDR_W] == ADDR_W'(DEPTH - 1));
                end else check({tag, "_extra_pop"}, 1, 0);
                popped++;
                if (popped == DEPTH) fin_cyc = cyc;
            end
            if (poke && !poked && popped == 5) begin
                poke_now = 1;
                poked = 1;
            end
            stall = W_VALID && !rdy;
            pdata = W_DATA;
            pidx  = W_IDX;
            @(posedge CLK); #1;
            cyc++;
            if (fin_cyc >= 0 && cyc > fin_cyc + 3) break;
        end
        START = 1'b0;
        W_READY = 1'b0;
        check({tag, "_popped"}, popped, DEPTH);
        check({tag, "_issued"}, issued, DEPTH);
        check({tag, "_dones"}, dones, 1);
        if (mode == 0) check({tag, "_fin_cyc"}, fin_cyc, DEPTH + 1);
    endtask

    initial begin
        int n;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_wvalid", W_VALID, 0);
        check("rst_wlast", W_LAST, 0);
        check("rst_wdata", W_DATA, 0);
        check("rst_widx", W_IDX, 0);
        check("rst_en", BRAM_EN, 0);
        check("rst_we", BRAM_WE, 0);
        check("rst_addr", BRAM_ADDR, 0);
        check("rst_di", BRAM_DI, 0);
        check("rst_hready", HOST_READY, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        run_load(1'b0, 1'b1, "load_a");
        idle_cycles(3, "after_load");
        run_fetch(0, 1'b1, "fetch_full");
        idle_cycles(2, "after_full");
        run_fetch(1, 1'b0, "fetch_bp");
        run_fetch(3, 1'b0, "fetch_hold");
        run_load(1'b1, 1'b0, "load_rnd");
        run_fetch(2, 1'b0, "fetch_rnd");

        // Abort a fetch at index 12 with an asynchronous reset.
        START = 1'b1;
        W_READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge CLK);
            if (W_VALID && W_IDX == ADDR_W'(12)) break;
            n++;
            @(posedge CLK); #1;
        end
        check("rst_mid_reach", n < 100, 1);
        #1 RST_N = 1'b0;
        #1;
        check("rst_mid_wvalid", W_VALID, 0);
        check("rst_mid_busy", BUSY, 0);
        check("rst_mid_en", BRAM_EN, 0);
        check("rst_mid_done", DONE, 0);
        @(posedge CLK); #1;
        check("rst_mid_done2", DONE, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        W_READY = 1'b0;
        @(posedge CLK); #1;
        idle_cycles(4, "post_rst");
        run_fetch(0, 1'b0, "refetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
